pmem_arb_ctrl: RTL
==================

PMEM_ARB_CTRL -- requirements
Module: pmem_arb_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, max BUSY cycles before abort (range 2..255).
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_read  input  1  icache line-read request.
REQ-006 SHALL have i_address  input  32  icache line address.
REQ-007 SHALL have i_resp, i_error  output  1 each  icache completion / error pulse.
REQ-008 SHALL have d_read, d_write  input  1 each  dcache line read / writeback request.
REQ-009 SHALL have d_address  input  32  dcache line address.
REQ-010 SHALL have d_wdata  input  LINE_W  dcache writeback data.
REQ-011 SHALL have d_resp, d_error  output  1 each  dcache completion / error pulse.
REQ-012 SHALL have cache_rdata  output  LINE_W  read data to both caches.
REQ-013 SHALL have pmem_resp, pmem_error  input  1 each  memory completion / error.
REQ-014 SHALL have pmem_rdata  input  LINE_W  memory read data.
REQ-015 SHALL have pmem_read, pmem_write  output  1 each  memory command.
REQ-016 SHALL have pmem_address  output  32; pmem_wdata  output  LINE_W.

Function
REQ-017 SHALL implement FSM states IDLE, I_BUSY, D_BUSY.
REQ-018 SHALL sample requests only in IDLE; requests in BUSY states are ignored until return to IDLE.
REQ-019 IDLE, only icache requesting: next state I_BUSY; only dcache (d_read|d_write): next D_BUSY; none: stay IDLE.
REQ-020 IDLE, both requesting: SHALL grant the side not recorded in last_grant (round-robin); last_grant updates on every grant.
REQ-021 On grant SHALL latch address, op (read/write) and d_wdata into registers; pmem_address/pmem_wdata/pmem_read/pmem_write driven only from these registers.
REQ-022 d_read and d_write both high SHALL be treated as a write.
REQ-023 pmem_read/pmem_write SHALL be asserted every cycle in BUSY and low in IDLE; arbitration latency exactly 1 cycle (request in IDLE cycle N -> command at cycle N+1).
REQ-024 In BUSY, pmem_resp high SHALL combinationally pulse the owner's resp that cycle only; non-owner resp stays 0; next state IDLE.
REQ-025 In BUSY, pmem_error high SHALL pulse owner's error and owner's resp same cycle; next state IDLE.
REQ-026 cache_rdata SHALL equal pmem_rdata combinationally.
REQ-027 SHALL count BUSY cycles with 8-bit counter cleared on entry; when count reaches TIMEOUT with no pmem_resp/pmem_error, pulse owner's error and resp, return to IDLE.
REQ-028 pmem_resp/pmem_error in IDLE SHALL be ignored (no resp/error pulses, no state change).
REQ-029 Same-cycle pmem_resp and timeout SHALL be a normal completion (resp only, no error).

Reset
REQ-030 rst SHALL immediately force state IDLE, last_grant = D (icache wins first tie), counter 0, latched address/wdata 0.
REQ-031 During reset all outputs except cache_rdata SHALL be 0; reset mid-transaction abandons it without resp/error pulse.

Verification
REQ-032 Icache only: i_read=1, i_address=0x0000_1000 -> cycle+1 pmem_read=1, pmem_address=0x1000; pmem_resp 3 cycles later -> i_resp=1 one cycle, d_resp=0.
REQ-033 Tie: i_read=1,d_read=1 from reset, held -> grants I, then D, then I alternately; pmem_address alternates i/d addresses.
REQ-034 Writeback: d_write=1, d_address=0x2000, d_wdata=all-A5 -> pmem_write=1, pmem_wdata=all-A5, pmem_read=0; change d_wdata mid-BUSY -> pmem_wdata unchanged.
REQ-035 Timeout: TIMEOUT=4, d_read, no pmem_resp -> d_error and d_resp pulse on 4th BUSY cycle, pmem_read drops next cycle.
REQ-036 Reset mid-op: rst asserted in I_BUSY -> pmem_read=0 same cycle, no i_resp; after release idle, next tie grants icache.
REQ-037 Stray pmem_resp in IDLE -> i_resp=d_resp=0, state stays IDLE.

Source files
------------

// File: rtl/pmem_arb_ctrl.sv
// Round-robin arbiter between an icache and a dcache for one physical memory port.
// A grant latches the request; the memory command is held until resp, error or timeout.
module pmem_arb_ctrl #(
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic              i_resp,
    output logic              i_error,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic              d_error,
    output logic [LINE_W-1:0] cache_rdata,
    input  logic              pmem_resp,
    input  logic              pmem_error,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken only while IDLE; the owner sees exactly one
    // resp pulse (with error on abort) in the cycle its transaction ends.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t            state;
    logic              last_grant_d;
    logic [7:0]        busy_cnt;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              pmem_read_q;
    logic              pmem_write_q;

    logic busy;
    logic timeout;
    logic done;
    logic err;
    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    always_comb begin
        busy    = (state != IDLE);
        // busy_cnt holds completed BUSY cycles, so this fires on the TIMEOUT-th one
        timeout = busy && (busy_cnt == LAST_CNT);
        done    = busy && (pmem_resp || pmem_error || timeout);
        err     = busy && (pmem_error || (timeout && !pmem_resp));
        i_req   = i_read;
        d_req   = d_read || d_write;
        grant_i = i_req && (!d_req || last_grant_d);
        grant_d = d_req && !grant_i;
    end

    always_comb begin
        i_resp       = done && (state == I_BUSY);
        i_error      = err  && (state == I_BUSY);
        d_resp       = done && (state == D_BUSY);
        d_error      = err  && (state == D_BUSY);
        cache_rdata  = pmem_rdata;
        pmem_read    = pmem_read_q;
        pmem_write   = pmem_write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        dbg_state    = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            busy_cnt     <= 8'd0;
            addr_q       <= 32'd0;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= I_BUSY;
                        last_grant_d <= 1'b0;
                        busy_cnt     <= 8'd0;
                        addr_q       <= i_address;
                        pmem_read_q  <= 1'b1;
                        pmem_write_q <= 1'b0;
                    end else if (grant_d) begin
                        // read and write together is a writeback
                        state        <= D_BUSY;
                        last_grant_d <= 1'b1;
                        busy_cnt     <= 8'd0;
                        addr_q       <= d_address;
                        wdata_q      <= d_wdata;
                        pmem_read_q  <= !d_write;
                        pmem_write_q <= d_write;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (done) begin
                        state        <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
